// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  // TX frame states. The three unused encodings fall back to IDLE.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Source of the next line value, decoded from the next state.
  // STOP shares the idle level, so it uses SEL_IDLE.
  typedef enum logic [1:0] {
    SEL_IDLE  = 2'd0,
    SEL_START = 2'd1,
    SEL_DATA  = 2'd2,
    SEL_PAR   = 2'd3
  } tx_sel_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_if.sv
// Controller <-> transmitter bundle: byte handshake in, serial line and busy out.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
                  input  TX_OUT, busy);
  modport slave  (input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
                  output TX_OUT, busy);
endinterface

// File: rtl/uart_tx_fsm.sv
// Frame sequencer: state register, next-state logic and decode of the
// busy / line-select values that the top registers alongside the state.
module uart_tx_fsm
  import uart_pkg::*;
(
  input  logic    CLK,
  input  logic    RST,
  input  logic    i_data_valid,
  input  logic    i_cnt_last,
  input  logic    i_par_en,
  output logic    o_accept,
  output logic    o_in_start,
  output logic    o_in_data,
  output logic    o_busy_nxt,
  output tx_sel_e o_sel_nxt
);

  tx_state_e r_state;
  tx_state_e w_state_nxt;
  logic      w_accept;

  // A new byte is taken only when the line is idle or finishing a stop bit.
  assign w_accept   = i_data_valid && ((r_state == TX_IDLE) || (r_state == TX_STOP));
  assign o_accept   = w_accept;
  assign o_in_start = (r_state == TX_START);
  assign o_in_data  = (r_state == TX_DATA);

  // State register, asynchronously cleared to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= TX_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: illegal encodings recover to IDLE.
  always_comb begin
    w_state_nxt = TX_IDLE;
    case (r_state)
      TX_IDLE:   w_state_nxt = w_accept ? TX_START : TX_IDLE;
      TX_START:  w_state_nxt = TX_DATA;
      TX_DATA:   w_state_nxt = i_cnt_last ? (i_par_en ? TX_PARITY : TX_STOP) : TX_DATA;
      TX_PARITY: w_state_nxt = TX_STOP;
      TX_STOP:   w_state_nxt = w_accept ? TX_START : TX_IDLE;
      default:   w_state_nxt = TX_IDLE;
    endcase
  end

  // Output decode from the next state so the top can register TX_OUT/busy.
  always_comb begin
    o_busy_nxt = 1'b1;
    o_sel_nxt  = SEL_IDLE;
    case (w_state_nxt)
      TX_IDLE:   o_busy_nxt = 1'b0;
      TX_START:  o_sel_nxt  = SEL_START;
      TX_DATA:   o_sel_nxt  = SEL_DATA;
      TX_PARITY: o_sel_nxt  = SEL_PAR;
      TX_STOP:   o_sel_nxt  = SEL_IDLE;
      default:   o_busy_nxt = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, stop bit; one bit per CLK cycle. TX_OUT and busy are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int            CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_par_en;
  logic                  r_par;
  logic                  r_tx_out;
  logic                  r_busy;

  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_par_nxt;
  logic                  w_line_nxt;
  logic                  w_accept;
  logic                  w_in_start;
  logic                  w_in_data;
  logic                  w_busy_nxt;
  tx_sel_e               w_sel_nxt;

  uart_tx_fsm u_fsm (
    .CLK          (CLK),
    .RST          (RST),
    .i_data_valid (bus.Data_Valid),
    .i_cnt_last   (r_cnt == LAST),
    .i_par_en     (r_par_en),
    .o_accept     (w_accept),
    .o_in_start   (w_in_start),
    .o_in_data    (w_in_data),
    .o_busy_nxt   (w_busy_nxt),
    .o_sel_nxt    (w_sel_nxt)
  );

  // Next shift/parity contents; the line flop looks ahead at these so that
  // the bit presented after an edge is the one belonging to the new state.
  always_comb begin
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    if (w_accept) begin
      w_shift_nxt = bus.P_DATA;
      w_par_nxt   = (^bus.P_DATA) ^ bus.PAR_TYP;
    end else if (w_in_data) begin
      w_shift_nxt = r_shift >> 1;
    end
  end

  // Line value for the next state.
  always_comb begin
    w_line_nxt = UART_IDLE_LEVEL;
    case (w_sel_nxt)
      SEL_IDLE:  w_line_nxt = UART_IDLE_LEVEL;
      SEL_START: w_line_nxt = UART_START_LEVEL;
      SEL_DATA:  w_line_nxt = w_shift_nxt[0];
      SEL_PAR:   w_line_nxt = w_par_nxt;
      default:   w_line_nxt = UART_IDLE_LEVEL;
    endcase
  end

  // Datapath and output flops; reset drives the line high immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_tx_out <= UART_IDLE_LEVEL;
      r_busy   <= 1'b0;
    end else begin
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_tx_out <= w_line_nxt;
      r_busy   <= w_busy_nxt;
      if (w_accept)        r_par_en <= bus.PAR_EN;
      if (w_in_start)      r_cnt    <= '0;
      else if (w_in_data)  r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign bus.TX_OUT = r_tx_out;
  assign bus.busy   = r_busy;

endmodule
